// File: rtl/cmsdk_ahb_flash_prog_ctrl.sv
// cmsdk_ahb_flash_prog_ctrl
// AHB-Lite register slave that sequences word-program and page-erase
// operations on the embedded flash macro. A KEY write arms the block for
// exactly one operation; a CMD write then runs setup, strobe and hold
// phases with parameterised cycle counts. STATUS reports BUSY/DONE/ERR and
// a completion interrupt is raised when DONE and IE are both set.

module cmsdk_ahb_flash_prog_ctrl #(
    parameter int AW     = 16,
    parameter int TSU    = 2,
    parameter int TPROG  = 40,
    parameter int TERASE = 4000,
    parameter int THOLD  = 2
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [11:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic [2:0]    HSIZE,
    input  logic          HWRITE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    output logic [AW-3:0] FLASHADDR,
    output logic [31:0]   FLASHWDATA,
    output logic          FLASHPROG,
    output logic          FLASHERASE,
    output logic          FLASHIRQ
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [2:0]  IDX_ADDR   = 3'd0;
    localparam logic [2:0]  IDX_WDATA  = 3'd1;
    localparam logic [2:0]  IDX_CMD    = 3'd2;
    localparam logic [2:0]  IDX_STATUS = 3'd3;
    localparam logic [2:0]  IDX_CTRL   = 3'd4;
    localparam logic [2:0]  IDX_KEY    = 3'd5;

    localparam logic [31:0] KEY_VALUE  = 32'h0000_F1A5;
    localparam logic [31:0] CMD_PROG   = 32'h0000_0001;
    localparam logic [31:0] CMD_ERASE  = 32'h0000_0002;

    // Counter reload values; the counter holds "cycles remaining minus one".
    localparam logic [15:0] TSU_LOAD    = 16'(TSU - 1);
    localparam logic [15:0] TPROG_LOAD  = 16'(TPROG - 1);
    localparam logic [15:0] TERASE_LOAD = 16'(TERASE - 1);
    localparam logic [15:0] THOLD_LOAD  = 16'(THOLD - 1);

    // Address-phase capture
    logic          rd_phase_r;
    logic          wr_phase_r;
    logic [2:0]    reg_idx_r;
    logic          reg_hit_r;

    // Programmer-visible registers
    logic [AW-3:0] addr_r;
    logic [31:0]   wdata_r;
    logic          ie_r;
    logic          done_r;
    logic          err_r;
    logic          unlocked_r;
    logic          irq_r;

    // Operation sequencer
    state_t        state_r;
    logic [15:0]   cnt_r;
    logic          op_erase_r;
    logic          prog_r;
    logic          erase_r;

    // Decoded data-phase events
    logic          valid_s;
    logic          busy_s;
    logic          wr_sel_s;
    logic          wr_addr_s;
    logic          wr_wdata_s;
    logic          wr_cmd_s;
    logic          wr_status_s;
    logic          wr_ctrl_s;
    logic          wr_key_s;
    logic          cmd_valid_s;
    logic          cmd_ok_s;
    logic          err_set_s;
    logic          done_set_s;
    logic          done_nxt_s;
    logic          err_nxt_s;
    logic          ie_nxt_s;
    logic          unlocked_nxt_s;
    logic [31:0]   rdata_s;
    logic          unused_ok_s;

    assign valid_s     = HSEL & HTRANS[1] & HREADY;
    assign busy_s      = (state_r != ST_IDLE);
    assign unused_ok_s = &{1'b0, HSIZE, HADDR[1:0], HTRANS[0]};

    // Capture transfer attributes during the address phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rd_phase_r <= 1'b0;
            wr_phase_r <= 1'b0;
            reg_idx_r  <= 3'd0;
            reg_hit_r  <= 1'b0;
        end else begin
            rd_phase_r <= valid_s & ~HWRITE;
            wr_phase_r <= valid_s & HWRITE;
            reg_idx_r  <= HADDR[4:2];
            reg_hit_r  <= (HADDR[11:5] == 7'd0);
        end
    end

    // Decode data-phase writes and the error / completion events they cause
    always_comb begin
        wr_sel_s    = wr_phase_r & reg_hit_r;
        wr_addr_s   = wr_sel_s & (reg_idx_r == IDX_ADDR);
        wr_wdata_s  = wr_sel_s & (reg_idx_r == IDX_WDATA);
        wr_cmd_s    = wr_sel_s & (reg_idx_r == IDX_CMD);
        wr_status_s = wr_sel_s & (reg_idx_r == IDX_STATUS);
        wr_ctrl_s   = wr_sel_s & (reg_idx_r == IDX_CTRL);
        wr_key_s    = wr_sel_s & (reg_idx_r == IDX_KEY);
        cmd_valid_s = (HWDATA == CMD_PROG) | (HWDATA == CMD_ERASE);
        cmd_ok_s    = wr_cmd_s & cmd_valid_s & unlocked_r & ~busy_s;
        // Rejected command (locked or busy) or a configuration write while busy
        err_set_s   = (wr_cmd_s & cmd_valid_s & (~unlocked_r | busy_s))
                    | ((wr_addr_s | wr_wdata_s | wr_key_s) & busy_s);
        done_set_s  = (state_r == ST_HOLD) & (cnt_r == 16'd0);
    end

    // Next values of the status/control bits; hardware sets beat W1C clears
    always_comb begin
        if (done_set_s) begin
            done_nxt_s = 1'b1;
        end else if (wr_status_s & HWDATA[1]) begin
            done_nxt_s = 1'b0;
        end else begin
            done_nxt_s = done_r;
        end

        if (err_set_s) begin
            err_nxt_s = 1'b1;
        end else if (wr_status_s & HWDATA[2]) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end

        if (wr_ctrl_s) begin
            ie_nxt_s = HWDATA[0];
        end else begin
            ie_nxt_s = ie_r;
        end

        if (cmd_ok_s) begin
            unlocked_nxt_s = 1'b0;
        end else if (wr_key_s & ~busy_s) begin
            unlocked_nxt_s = (HWDATA == KEY_VALUE);
        end else begin
            unlocked_nxt_s = unlocked_r;
        end
    end

    // Register file update; ADDR/WDATA are frozen while an operation runs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_r     <= '0;
            wdata_r    <= 32'd0;
            ie_r       <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            unlocked_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (wr_addr_s & ~busy_s) begin
                addr_r <= HWDATA[AW-3:0];
            end
            if (wr_wdata_s & ~busy_s) begin
                wdata_r <= HWDATA;
            end
            ie_r       <= ie_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            unlocked_r <= unlocked_nxt_s;
            // Built from next-state values so IRQ tracks DONE & IE without lag
            irq_r      <= done_nxt_s & ie_nxt_s;
        end
    end

    // Operation sequencer with registered, glitch-free strobes
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 16'd0;
            op_erase_r <= 1'b0;
            prog_r     <= 1'b0;
            erase_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    prog_r  <= 1'b0;
                    erase_r <= 1'b0;
                    if (cmd_ok_s) begin
                        state_r    <= ST_SETUP;
                        op_erase_r <= (HWDATA == CMD_ERASE);
                        cnt_r      <= TSU_LOAD;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= ST_PULSE;
                        cnt_r   <= op_erase_r ? TERASE_LOAD : TPROG_LOAD;
                        prog_r  <= ~op_erase_r;
                        erase_r <= op_erase_r;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_PULSE: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= ST_HOLD;
                        cnt_r   <= THOLD_LOAD;
                        prog_r  <= 1'b0;
                        erase_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == 16'd0) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 16'd0;
                    prog_r  <= 1'b0;
                    erase_r <= 1'b0;
                end
            endcase
        end
    end

    // Read-data mux driven from the registered register index
    always_comb begin
        rdata_s = 32'd0;
        if (rd_phase_r & reg_hit_r) begin
            case (reg_idx_r)
                IDX_ADDR:   rdata_s = {{(34-AW){1'b0}}, addr_r};
                IDX_WDATA:  rdata_s = wdata_r;
                IDX_STATUS: rdata_s = {28'd0, unlocked_r, err_r, done_r, busy_s};
                IDX_CTRL:   rdata_s = {31'd0, ie_r};
                default:    rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

    assign HREADYOUT  = 1'b1;
    assign HRESP      = 1'b0;
    assign HRDATA     = rdata_s;
    assign FLASHADDR  = addr_r;
    assign FLASHWDATA = wdata_r;
    assign FLASHPROG  = prog_r;
    assign FLASHERASE = erase_r;
    assign FLASHIRQ   = irq_r;

endmodule

// File: tb/tb_cmsdk_ahb_flash_prog_ctrl.sv
// Self-checking bench for cmsdk_ahb_flash_prog_ctrl: register access vectors
// from a table, then directed multi-cycle program/erase/IRQ/reset sequences.

module tb_cmsdk_ahb_flash_prog_ctrl;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [11:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [13:0] FLASHADDR;
    logic [31:0] FLASHWDATA;
    logic        FLASHPROG;
    logic        FLASHERASE;
    logic        FLASHIRQ;

    cmsdk_ahb_flash_prog_ctrl #(
        .AW(16), .TSU(2), .TPROG(40), .TERASE(4000), .THOLD(2)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
        .FLASHADDR(FLASHADDR), .FLASHWDATA(FLASHWDATA), .FLASHPROG(FLASHPROG),
        .FLASHERASE(FLASHERASE), .FLASHIRQ(FLASHIRQ)
    );

    localparam logic [11:0] A_ADDR   = 12'h000;
    localparam logic [11:0] A_WDATA  = 12'h004;
    localparam logic [11:0] A_CMD    = 12'h008;
    localparam logic [11:0] A_STATUS = 12'h00C;
    localparam logic [11:0] A_CTRL   = 12'h010;
    localparam logic [11:0] A_KEY    = 12'h014;
    localparam logic [11:0] A_UNMAP  = 12'h018;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    // Free-running strobe observers
    int   cyc = 0;
    int   prog_hi = 0;
    int   erase_hi = 0;
    int   prog_rise = 0;
    logic prog_prev = 1'b0;

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Count cycles and strobe-high cycles at each falling edge
    always @(negedge HCLK) begin
        cyc = cyc + 1;
        if (FLASHPROG) prog_hi = prog_hi + 1;
        if (FLASHERASE) erase_hi = erase_hi + 1;
        if (FLASHPROG && !prog_prev) prog_rise = cyc;
        prog_prev = FLASHPROG;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ahb_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
        @(posedge HCLK);
    endtask

    task automatic ahb_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge HCLK);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
        @(negedge HCLK);
        HSEL = 1'b0; HTRANS = 2'b00;
        d = HRDATA;
        @(posedge HCLK);
    endtask

    task automatic add(input logic wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] rd;
        int cmd_cyc;
        int p0;
        int e0;
        int n;

        HRESETn = 1'b0; HSEL = 1'b0; HADDR = 12'h000; HTRANS = 2'b00;
        HSIZE = 3'b010; HWRITE = 1'b0; HWDATA = 32'd0; HREADY = 1'b1;

        // Register access vectors: reset values, then RW/WO/W1C behaviour
        add(1'b0, A_ADDR,   32'd0, 32'h0000_0000);
        add(1'b0, A_WDATA,  32'd0, 32'h0000_0000);
        add(1'b0, A_CMD,    32'd0, 32'h0000_0000);
        add(1'b0, A_STATUS, 32'd0, 32'h0000_0000);
        add(1'b0, A_CTRL,   32'd0, 32'h0000_0000);
        add(1'b0, A_KEY,    32'd0, 32'h0000_0000);
        add(1'b0, A_UNMAP,  32'd0, 32'h0000_0000);
        add(1'b1, A_ADDR,   32'hFFFF_FFFF, 32'd0);
        add(1'b0, A_ADDR,   32'd0, 32'h0000_3FFF);
        add(1'b1, A_WDATA,  32'hA5A5_5A5A, 32'd0);
        add(1'b0, A_WDATA,  32'd0, 32'hA5A5_5A5A);
        add(1'b1, A_CTRL,   32'hFFFF_FFFF, 32'd0);
        add(1'b0, A_CTRL,   32'd0, 32'h0000_0001);
        add(1'b1, A_CTRL,   32'h0000_0000, 32'd0);
        add(1'b0, A_CTRL,   32'd0, 32'h0000_0000);
        add(1'b1, A_KEY,    32'h0000_F1A5, 32'd0);
        add(1'b0, A_STATUS, 32'd0, 32'h0000_0008);
        add(1'b1, A_CMD,    32'h0000_0003, 32'd0);
        add(1'b0, A_STATUS, 32'd0, 32'h0000_0008);
        add(1'b0, A_KEY,    32'd0, 32'h0000_0000);
        add(1'b1, A_KEY,    32'h0000_1234, 32'd0);
        add(1'b0, A_STATUS, 32'd0, 32'h0000_0000);
        add(1'b1, A_UNMAP,  32'hFFFF_FFFF, 32'd0);
        add(1'b0, A_UNMAP,  32'd0, 32'h0000_0000);
        add(1'b1, A_STATUS, 32'h0000_000F, 32'd0);
        add(1'b0, A_STATUS, 32'd0, 32'h0000_0000);
        add(1'b1, A_ADDR,   32'h0000_0123, 32'd0);
        add(1'b1, A_WDATA,  32'hDEAD_BEEF, 32'd0);
        add(1'b0, A_CMD,    32'd0, 32'h0000_0000);

        repeat (3) @(negedge HCLK);
        HRESETn = 1'b1;

        check("reset_hreadyout", {31'd0, HREADYOUT}, 32'd1);
        check("reset_hresp", {31'd0, HRESP}, 32'd0);
        check("reset_hrdata", HRDATA, 32'd0);
        check("reset_strobes", {29'd0, FLASHPROG, FLASHERASE, FLASHIRQ}, 32'd0);
        check("reset_flashaddr", {18'd0, FLASHADDR}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                ahb_write(vecs[i].addr, vecs[i].data);
            end else begin
                ahb_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), rd, vecs[i].exp);
            end
        end
        check("mirror_addr", {18'd0, FLASHADDR}, 32'h0000_0123);
        check("mirror_wdata", FLASHWDATA, 32'hDEAD_BEEF);

        // Word program: strobe position/width and busy duration
        ahb_write(A_KEY, 32'h0000_F1A5);
        p0 = prog_hi; e0 = erase_hi;
        ahb_write(A_CMD, 32'h0000_0001);
        cmd_cyc = cyc;
        n = 0;
        do begin
            ahb_read(A_STATUS, rd);
            n++;
        end while (rd[0] && n < 100);
        check("prog_busy_reads_even", n, 32'd23);
        check("prog_rise_offset", prog_rise - cmd_cyc, 32'd3);
        check("prog_width", prog_hi - p0, 32'd40);
        check("prog_no_erase", erase_hi - e0, 32'd0);
        check("prog_status_done", rd, 32'h0000_0002);
        check("prog_flashaddr", {18'd0, FLASHADDR}, 32'h0000_0123);
        check("prog_irq_ie0", {31'd0, FLASHIRQ}, 32'd0);
        ahb_write(A_STATUS, 32'h0000_0002);

        // Erase command while locked is rejected
        e0 = erase_hi;
        ahb_write(A_CMD, 32'h0000_0002);
        repeat (6) @(negedge HCLK);
        ahb_read(A_STATUS, rd);
        check("locked_cmd_err", rd, 32'h0000_0004);
        check("locked_no_erase", erase_hi - e0, 32'd0);
        ahb_write(A_STATUS, 32'h0000_0004);
        ahb_read(A_STATUS, rd);
        check("err_w1c", rd, 32'h0000_0000);

        // Erase with rejected writes during the pulse
        ahb_write(A_KEY, 32'h0000_F1A5);
        e0 = erase_hi;
        ahb_write(A_CMD, 32'h0000_0002);
        repeat (10) @(negedge HCLK);
        check("erase_strobe_high", {31'd0, FLASHERASE}, 32'd1);
        ahb_write(A_WDATA, 32'h0000_0055);
        ahb_write(A_CMD, 32'h0000_0001);
        ahb_write(A_ADDR, 32'h0000_0007);
        ahb_read(A_WDATA, rd);
        check("busy_wdata_kept", rd, 32'hDEAD_BEEF);
        ahb_read(A_STATUS, rd);
        check("busy_status", rd, 32'h0000_0005);
        n = 0;
        do begin
            ahb_read(A_STATUS, rd);
            n++;
        end while (rd[0] && n < 3000);
        check("erase_complete", {31'd0, rd[0]}, 32'd0);
        check("erase_width", erase_hi - e0, 32'd4000);
        check("erase_status", rd, 32'h0000_0006);
        ahb_read(A_ADDR, rd);
        check("busy_addr_kept", rd, 32'h0000_0123);
        ahb_write(A_STATUS, 32'h0000_0006);

        // Interrupt on completion, odd-phase busy poll, then W1C clear
        ahb_write(A_CTRL, 32'h0000_0001);
        ahb_write(A_KEY, 32'h0000_F1A5);
        ahb_write(A_CMD, 32'h0000_0001);
        @(negedge HCLK);
        n = 0;
        do begin
            ahb_read(A_STATUS, rd);
            n++;
        end while (rd[0] && n < 100);
        check("prog_busy_reads_odd", n, 32'd22);
        check("irq_set", {31'd0, FLASHIRQ}, 32'd1);
        ahb_write(A_STATUS, 32'h0000_0002);
        @(negedge HCLK);
        check("irq_cleared", {31'd0, FLASHIRQ}, 32'd0);
        ahb_read(A_STATUS, rd);
        check("done_cleared", rd, 32'h0000_0000);

        // W1C of DONE landing on the completion cycle loses to the set
        ahb_write(A_KEY, 32'h0000_F1A5);
        ahb_write(A_CMD, 32'h0000_0001);
        repeat (42) @(negedge HCLK);
        ahb_write(A_STATUS, 32'h0000_0002);
        ahb_read(A_STATUS, rd);
        check("w1c_race_done", rd, 32'h0000_0002);
        check("w1c_race_irq", {31'd0, FLASHIRQ}, 32'd1);
        ahb_write(A_STATUS, 32'h0000_0002);

        // Reset in the middle of a program pulse
        ahb_write(A_KEY, 32'h0000_F1A5);
        ahb_write(A_CMD, 32'h0000_0001);
        repeat (10) @(negedge HCLK);
        check("pre_reset_prog", {31'd0, FLASHPROG}, 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("reset_drops_prog", {31'd0, FLASHPROG}, 32'd0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        ahb_read(A_STATUS, rd);
        check("post_reset_status", rd, 32'h0000_0000);
        ahb_read(A_CTRL, rd);
        check("post_reset_ctrl", rd, 32'h0000_0000);
        repeat (50) @(negedge HCLK);
        check("post_reset_no_strobe", {30'd0, FLASHPROG, FLASHERASE}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmsdk_ahb_flash_prog_ctrl.md
Name: cmsdk_ahb_flash_prog_ctrl

Overview:
- AHB-Lite register slave that sequences word-program and page-erase operations on the embedded flash macro.
- Write-side companion to the read-only AHB flash interface; sits on the APB/AHB peripheral region.
- Drives the macro's program/erase strobes with parameterised setup, pulse and hold timing.
- Reports BUSY/DONE/ERR status and raises an interrupt when an operation completes.

Parameters:
- AW, 16, flash byte-address width; the flash word address is AW-2 bits.
- TSU, 2, setup cycles (address/data stable before strobe), 1..65535.
- TPROG, 40, FLASHPROG pulse width in HCLK cycles, 1..65535.
- TERASE, 4000, FLASHERASE pulse width in HCLK cycles, 1..65535.
- THOLD, 2, hold cycles after the strobe falls, 1..65535.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset, asynchronous, active-low
- HSEL  in  1  slave select
- HADDR  in  12  address; HADDR[4:2] selects the register
- HTRANS  in  2  transfer type
- HSIZE  in  3  ignored
- HWRITE  in  1  write control
- HWDATA  in  32  write data
- HREADY  in  1  transfer done
- HREADYOUT  out  1  always 1
- HRDATA  out  32  read data
- HRESP  out  1  always 0
- FLASHADDR  out  AW-2  program/erase word address
- FLASHWDATA  out  32  program data
- FLASHPROG  out  1  program strobe
- FLASHERASE  out  1  erase strobe
- FLASHIRQ  out  1  completion interrupt

Behaviour:
- Transfer qualification: access valid = HSEL & HTRANS[1] & HREADY. Address, write flag and register index are registered in the address phase.
- Data phase: writes use HWDATA in the data phase. Reads are combinational from the registered index, and HRDATA = 0 when there is no read data phase.
- Register map:
  - 0x00 ADDR, RW, [AW-3:0].
  - 0x04 WDATA, RW, [31:0].
  - 0x08 CMD, WO, reads 0. Value 1 = program, value 2 = erase, other values are ignored with no error.
  - 0x0C STATUS: bit0 BUSY (RO), bit1 DONE (W1C), bit2 ERR (W1C), bit3 UNLOCKED (RO).
  - 0x10 CTRL, RW: bit0 IE.
  - 0x14 KEY, WO: writing 0x0000F1A5 sets UNLOCKED; any other value clears it.
  - Unmapped offsets read 0; writes to them are ignored.
- Reset values: all registers 0, FSM in IDLE, FLASHPROG = 0, FLASHERASE = 0, FLASHIRQ = 0, HRDATA = 0, FLASHADDR = 0, FLASHWDATA = 0.
- FLASHADDR and FLASHWDATA continuously mirror ADDR and WDATA.
- FSM states: IDLE, SETUP, PULSE, HOLD.
  - IDLE: a valid CMD write (1 or 2) with UNLOCKED = 1 and BUSY = 0 moves to SETUP on the next edge. The same edge clears UNLOCKED, sets BUSY, latches the op type and loads counter = TSU-1.
  - SETUP: counter decrements. At 0, go to PULSE and load TPROG-1 or TERASE-1.
  - PULSE: FLASHPROG or FLASHERASE is high, as selected. At 0, go to HOLD and load THOLD-1.
  - HOLD: at 0, go to IDLE, clear BUSY, set DONE.
  - Total BUSY duration = TSU + Tpulse + THOLD cycles. The strobe is exactly Tpulse cycles wide and registered, so it is glitch-free.
- Counter: 16 bits, decrement only, never wraps.
- ERR is set by each of the following; the rejected write has no other effect:
  - CMD 1/2 written while locked;
  - CMD 1/2 written while BUSY;
  - a write to ADDR, WDATA or KEY while BUSY.
- FLASHIRQ = DONE & IE, registered.
- Simultaneous events: a hardware set of DONE or ERR wins over a W1C clear in the same cycle.
- Reset mid-operation: the strobe drops asynchronously, the FSM returns to IDLE and no status is retained.

Test Plan:
- After reset, read all registers -> all 0; HREADYOUT = 1, HRESP = 0.
- Write KEY = 0x0000F1A5, ADDR = 0x123, WDATA = 0xDEADBEEF, CMD = 1 (TSU = 2, TPROG = 40, THOLD = 2) -> BUSY for 44 cycles; FLASHPROG high for exactly 40 cycles starting 2 cycles after the CMD data phase; then DONE = 1, UNLOCKED = 0, FLASHADDR = 0x123.
- Write CMD = 2 without writing KEY -> ERR = 1, FLASHERASE stays 0, BUSY stays 0.
- Unlock and start an erase, then write WDATA = 0x55 and CMD = 1 during PULSE -> WDATA is unchanged, ERR = 1, FLASHERASE stays high for the full 4000 cycles.
- IE = 1 and an operation completes -> FLASHIRQ = 1. Write STATUS = 0x2 -> DONE = 0 and FLASHIRQ = 0 on the next cycle. A W1C landing on the completion cycle -> DONE remains 1.
- Assert HRESETn low in the middle of PULSE -> FLASHPROG = 0 immediately; after release, STATUS = 0 and the FSM is in IDLE.
